if_fetch_stage: RTL and testbench

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

---
 rtl/if_fetch_stage_pkg.sv | 18 +
 rtl/if_fetch_stage_if_id_reg.sv | 34 +++
 rtl/if_fetch_stage.sv | 88 ++++++++
 tb/tb_if_fetch_stage.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared CPU definitions used by the fetch stage and its IF/ID register.
package if_fetch_stage_pkg;

  localparam int PC_W    = 12;
  localparam int INSTR_W = 16;
  localparam int OP_W    = 4;
  localparam int CNT_W   = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR       = 16'h0000;
  localparam logic [OP_W-1:0]    HALT_OP_DEFAULT = 4'b1111;

  // Fetch FSM: RUN fetches one instruction per cycle, HALT stops fetching.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register. A bubble (NOP, pc 0, invalid) takes priority
// over load; with neither asserted the contents are held.
module if_id_reg
  import if_fetch_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               bubble,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc_in,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc,
  output logic               valid
);

  // Register update: reset/bubble clears, load captures, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= NOP_INSTR;
      pc    <= '0;
      valid <= 1'b0;
    end else if (bubble) begin
      instr <= NOP_INSTR;
      pc    <= '0;
      valid <= 1'b0;
    end else if (load) begin
      instr <= instr_in;
      pc    <= pc_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, RUN/HALT fetch FSM, accepted
// instruction counter and the IF/ID register. Memory is combinational,
// so the word at imem_addr arrives in the same cycle it is addressed.
// Per-cycle priority: br_taken > flush > stall > normal advance.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 12'h000,
  parameter logic [OP_W-1:0] HALT_OP  = HALT_OP_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               flush,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic               if_id_valid,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_cnt
);

  fetch_state_t      state, state_next;
  logic [PC_W-1:0]   pc, pc_next;
  logic              ld, bub, cnt_inc;

  // State, PC and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      pc        <= RESET_PC;
      fetch_cnt <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (cnt_inc) fetch_cnt <= fetch_cnt + CNT_W'(1);
    end
  end

  // Next-state, next-PC and IF/ID control decode.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    ld         = 1'b0;
    bub        = 1'b0;
    cnt_inc    = 1'b0;
    if (br_taken) begin
      // Redirect wins over everything and restarts fetch from HALT.
      pc_next    = br_target;
      bub        = 1'b1;
      state_next = ST_RUN;
    end else if (flush) begin
      // Squash IF/ID; PC still advances unless stalled or halted.
      bub = 1'b1;
      if (!stall && state == ST_RUN) pc_next = pc + PC_W'(1);
    end else if (stall) begin
      // Everything holds.
      pc_next = pc;
    end else if (state == ST_RUN) begin
      pc_next = pc + PC_W'(1);
      ld      = 1'b1;
      cnt_inc = 1'b1;
      if (imem_data[INSTR_W-1 -: OP_W] == HALT_OP) state_next = ST_HALT;
    end else begin
      // HALT: decode consumed the held entry, replace it with a bubble.
      bub = 1'b1;
    end
  end

  assign imem_addr = pc;
  assign halted    = (state == ST_HALT);

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ld),
    .bubble   (bub),
    .instr_in (imem_data),
    .pc_in    (pc),
    .instr    (if_id_instr),
    .pc       (if_id_pc),
    .valid    (if_id_valid)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for the fetch stage with a combinational instruction memory.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [11:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall, flush, br_taken;
  logic [11:0] br_target;
  logic [15:0] if_id_instr;
  logic [11:0] if_id_pc;
  logic        if_id_valid;
  logic        halted;
  logic [15:0] fetch_cnt;

  logic [15:0] mem [0:4095];
  int n_checks = 0;
  int n_pass   = 0;

  assign imem_data = mem[imem_addr];

  if_fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .stall       (stall),
    .flush       (flush),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_valid (if_id_valid),
    .halted      (halted),
    .fetch_cnt   (fetch_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic f, input logic b, input logic [11:0] t);
    stall = s; flush = f; br_taken = b; br_target = t;
  endtask

  task automatic check_ifid(input string tag, input logic [15:0] ins, input logic [11:0] pc,
                            input logic v);
    check({tag, "_instr"}, if_id_instr, ins);
    check({tag, "_pc"},    if_id_pc,    pc);
    check({tag, "_valid"}, if_id_valid, v);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h1000 | 16'(i);
    mem[0] = 16'h6181;
    mem[8] = 16'hF000;
    rst_n = 1'b0;
    drive(0, 0, 0, 12'h000);
    #3;
    check("rst_addr", imem_addr, 12'h000);
    check_ifid("rst", 16'h0000, 12'h000, 1'b0);
    check("rst_cnt", fetch_cnt, 16'd0);
    check("rst_halted", halted, 1'b0);
    #9 rst_n = 1'b1;

    // free-running fetch from 0
    check("run_addr0", imem_addr, 12'h000);
    step();
    check("run_addr1", imem_addr, 12'h001);
    check_ifid("run0", 16'h6181, 12'h000, 1'b1);
    check("run_cnt1", fetch_cnt, 16'd1);
    step();
    check("run_addr2", imem_addr, 12'h002);
    step();
    check("run_addr3", imem_addr, 12'h003);
    check_ifid("run2", 16'h1002, 12'h002, 1'b1);
    check("run_cnt3", fetch_cnt, 16'd3);

    // stall two cycles at PC=3
    drive(1, 0, 0, 12'h000);
    for (int k = 0; k < 2; k++) begin
      step();
      check("stall_addr", imem_addr, 12'h003);
      check_ifid("stall", 16'h1002, 12'h002, 1'b1);
      check("stall_cnt", fetch_cnt, 16'd3);
    end
    drive(0, 0, 0, 12'h000);
    step();
    check("resume_addr", imem_addr, 12'h004);
    check_ifid("resume", 16'h1003, 12'h003, 1'b1);
    check("resume_cnt", fetch_cnt, 16'd4);

    // branch while stalled
    drive(1, 0, 1, 12'h006);
    step();
    check("br_addr", imem_addr, 12'h006);
    check_ifid("br_bub", 16'h0000, 12'h000, 1'b0);
    check("br_cnt", fetch_cnt, 16'd4);
    drive(0, 0, 0, 12'h000);
    step();
    check_ifid("br_tgt", 16'h1006, 12'h006, 1'b1);
    check("br_tgt_addr", imem_addr, 12'h007);
    check("br_tgt_cnt", fetch_cnt, 16'd5);

    // wrap at 4095
    drive(0, 1, 1, 12'hFFF);
    step();
    check("wrap_br_addr", imem_addr, 12'hFFF);
    check("wrap_br_valid", if_id_valid, 1'b0);
    drive(0, 0, 0, 12'h000);
    step();
    check("wrap_addr", imem_addr, 12'h000);
    check_ifid("wrap", 16'h1FFF, 12'hFFF, 1'b1);
    check("wrap_cnt", fetch_cnt, 16'd6);

    // flush with stall holds PC; flush alone advances
    drive(1, 1, 0, 12'h000);
    step();
    check("fl_st_addr", imem_addr, 12'h000);
    check_ifid("fl_st", 16'h0000, 12'h000, 1'b0);
    check("fl_st_cnt", fetch_cnt, 16'd6);
    drive(0, 1, 0, 12'h000);
    step();
    check("fl_addr", imem_addr, 12'h001);
    check("fl_valid", if_id_valid, 1'b0);
    check("fl_cnt", fetch_cnt, 16'd6);

    // halt instruction at 8
    drive(0, 0, 1, 12'h008);
    step();
    check("h_br_addr", imem_addr, 12'h008);
    drive(0, 0, 0, 12'h000);
    step();
    check("h_halted", halted, 1'b1);
    check("h_addr", imem_addr, 12'h009);
    check_ifid("h_latch", 16'hF000, 12'h008, 1'b1);
    check("h_cnt", fetch_cnt, 16'd7);
    drive(1, 0, 0, 12'h000);
    step();
    check("h_stall_valid", if_id_valid, 1'b1);
    check("h_stall_addr", imem_addr, 12'h009);
    drive(0, 0, 0, 12'h000);
    step();
    check_ifid("h_drain", 16'h0000, 12'h000, 1'b0);
    check("h_drain_addr", imem_addr, 12'h009);
    check("h_drain_halted", halted, 1'b1);
    step();
    check("h_frozen_addr", imem_addr, 12'h009);
    check("h_frozen_cnt", fetch_cnt, 16'd7);
    drive(0, 0, 1, 12'h000);
    step();
    check("h_exit_halted", halted, 1'b0);
    check("h_exit_addr", imem_addr, 12'h000);
    check("h_exit_valid", if_id_valid, 1'b0);
    drive(0, 0, 0, 12'h000);
    step();
    check_ifid("h_refetch", 16'h6181, 12'h000, 1'b1);
    check("h_refetch_cnt", fetch_cnt, 16'd8);

    // asynchronous reset while halted
    drive(0, 0, 1, 12'h008);
    step();
    drive(0, 0, 0, 12'h000);
    step();
    check("ar_pre_halted", halted, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("ar_addr", imem_addr, 12'h000);
    check_ifid("ar", 16'h0000, 12'h000, 1'b0);
    check("ar_cnt", fetch_cnt, 16'd0);
    check("ar_halted", halted, 1'b0);
    #2 rst_n = 1'b1;
    step();
    check_ifid("ar_first", 16'h6181, 12'h000, 1'b1);
    check("ar_first_cnt", fetch_cnt, 16'd1);
    check("ar_first_addr", imem_addr, 12'h001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
